pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush control and single-port bus arbiter.
// Define PIPE_CTRL_BUS_TIMEOUT_EN to enable the 255-cycle bus timeout.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        branch_flag,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    IF_XFER,
    MEM_XFER
  } state_t;

  state_t state, state_nx;
  logic   drop;
  logic   mem_go, if_go;
  logic   xfer, tmo, fin, drop_eff;

  // A request whose ack is being pulsed is already served.
  assign mem_go = mem_req && !mem_ack;
  assign if_go  = if_req && !if_ack;

  always_comb begin
    stall = 6'b000000;
    priority case (1'b1)
      mem_go:      stall = 6'b011111;
      stallreq_ex: stall = 6'b001111;
      stallreq_id: stall = 6'b000111;
      if_go:       stall = 6'b000011;
      default:     stall = 6'b000000;
    endcase
  end

  assign flush    = branch_flag && !stall[3];
  assign xfer     = state != IDLE;
  assign fin      = xfer && (bus_ack || tmo);
  assign drop_eff = drop || (flush && state == IF_XFER);

`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       tmo_q;

  assign tmo         = xfer && !bus_ack && tcnt == 8'd254;
  assign bus_timeout = tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt  <= 8'd0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo;
      tcnt  <= (xfer && !fin) ? tcnt + 8'd1 : 8'd0;
    end
  end
`else
  assign tmo         = 1'b0;
  assign bus_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (mem_go)     state_nx = MEM_XFER;
        else if (if_go) state_nx = IF_XFER;
      end
      IF_XFER,
      MEM_XFER: begin
        if (fin) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_sel   <= 4'd0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_go) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_sel   <= mem_sel;
            drop      <= 1'b0;
          end else if (if_go) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= 32'd0;
            bus_sel   <= 4'hf;
            drop      <= flush;
          end
        end
        IF_XFER: begin
          if (fin) begin
            bus_req <= 1'b0;
            drop    <= 1'b0;
            if (!drop_eff) begin
              if_ack   <= 1'b1;
              if_rdata <= tmo ? 32'd0 : bus_rdata;
            end
          end else begin
            drop <= drop_eff;
          end
        end
        MEM_XFER: begin
          if (fin) begin
            bus_req   <= 1'b0;
            mem_ack   <= 1'b1;
            mem_rdata <= tmo ? 32'd0 : bus_rdata;
          end
        end
        default: bus_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized check of pipe_ctrl
// against a transaction-level model of the arbiter and hazard rules.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, branch_flag;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [5:0]  stall;
  logic        flush, bus_timeout;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .branch_flag(branch_flag),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .flush(flush), .bus_timeout(bus_timeout)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: the transfer in flight (0 none, 1 fetch, 2 load/store).
  int          m_kind;
  logic [31:0] m_addr, m_wdata;
  logic        m_we, m_drop;
  logic [3:0]  m_sel;
  int          m_age;
  logic        m_if_ack, m_mem_ack, m_tmo;
  logic [31:0] m_if_rdata, m_mem_rdata;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [5:0] exp_stall();
    if (mem_req && !m_mem_ack) return 6'b011111;
    if (stallreq_ex)           return 6'b001111;
    if (stallreq_id)           return 6'b000111;
    if (if_req && !m_if_ack)   return 6'b000011;
    return 6'b000000;
  endfunction

  function automatic logic exp_flush();
    logic [5:0] s;
    s = exp_stall();
    return branch_flag && !s[3];
  endfunction

  task automatic model_reset();
    m_kind = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_drop = 0;
    m_sel = 0; m_age = 0; m_if_ack = 0; m_mem_ack = 0; m_tmo = 0;
    m_if_rdata = 0; m_mem_rdata = 0;
  endtask

  task automatic compare();
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("flush", 32'(flush), 32'(exp_flush()));
    chk("bus_req", 32'(bus_req), 32'(m_kind != 0));
    if (m_kind != 0) begin
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_we", 32'(bus_we), 32'(m_we));
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("bus_sel", 32'(bus_sel), 32'(m_sel));
    end
    chk("if_ack", 32'(if_ack), 32'(m_if_ack));
    chk("mem_ack", 32'(mem_ack), 32'(m_mem_ack));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("mem_rdata", mem_rdata, m_mem_rdata);
    chk("bus_timeout", 32'(bus_timeout), 32'(m_tmo));
  endtask

  task automatic model_update();
    logic fl, old_if, old_mem, to;
    fl = exp_flush();
    old_if = m_if_ack;
    old_mem = m_mem_ack;
    m_if_ack = 0; m_mem_ack = 0; m_tmo = 0;
    if (m_kind == 0) begin
      if (mem_req && !old_mem) begin
        m_kind = 2; m_addr = mem_addr; m_we = mem_we;
        m_wdata = mem_wdata; m_sel = mem_sel; m_drop = 0; m_age = 0;
      end else if (if_req && !old_if) begin
        m_kind = 1; m_addr = if_addr; m_we = 0;
        m_wdata = 0; m_sel = 4'hf; m_drop = fl; m_age = 0;
      end
    end else begin
      if (m_kind == 1 && fl) m_drop = 1;
      m_age++;
      to = TMO_EN && !bus_ack && m_age == 255;
      if (bus_ack || to) begin
        if (m_kind == 2) begin
          m_mem_ack = 1;
          m_mem_rdata = to ? 32'd0 : bus_rdata;
        end else if (!m_drop) begin
          m_if_ack = 1;
          m_if_rdata = to ? 32'd0 : bus_rdata;
        end
        m_tmo = to;
        m_kind = 0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare();
  endtask

  task automatic tick();
    if (!rst) model_reset();
    else model_update();
    @(posedge clk);
    #1;
  endtask

  logic last_if, last_mem, last_fl, seen;
  int   cnt;

  initial begin
    rst = 0; stallreq_id = 0; stallreq_ex = 0; branch_flag = 0;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_wdata = 0; mem_sel = 0;
    bus_ack = 0; bus_rdata = 0;
    model_reset();
    #2;
    chk("rst bus_req", 32'(bus_req), 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_sel", 32'(bus_sel), 32'h0);
    chk("rst acks", 32'({if_ack, mem_ack}), 32'h0);
    chk("rst rdata", if_rdata | mem_rdata, 32'h0);
    chk("rst stall", 32'(stall), 32'h0);
    chk("rst timeout", 32'(bus_timeout), 32'h0);
    @(posedge clk); #1;
    rst = 1;

    // Single fetch, bus_ack one cycle after bus_req.
    if_req = 1; if_addr = 32'h100;
    settle();
    chk("f stall0", 32'(stall), 32'h03);
    chk("f req0", 32'(bus_req), 32'h0);
    tick();
    settle();
    chk("f req1", 32'(bus_req), 32'h1);
    chk("f addr1", bus_addr, 32'h100);
    chk("f we1", 32'(bus_we), 32'h0);
    tick();
    bus_ack = 1; bus_rdata = 32'h13;
    settle();
    chk("f stall2", 32'(stall), 32'h03);
    tick();
    bus_ack = 0;
    settle();
    chk("f ack", 32'(if_ack), 32'h1);
    chk("f rdata", if_rdata, 32'h13);
    chk("f stall3", 32'(stall), 32'h00);
    tick();
    if_req = 0;
    settle();
    chk("f ack pulse", 32'(if_ack), 32'h0);
    tick();

    // Simultaneous fetch and store: store wins, then fetch.
    if_req = 1; if_addr = 32'h140;
    mem_req = 1; mem_we = 1; mem_addr = 32'h2000;
    mem_wdata = 32'hDEADBEEF; mem_sel = 4'hf;
    settle();
    chk("a stall0", 32'(stall), 32'h1f);
    tick();
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    settle();
    chk("a req", 32'(bus_req), 32'h1);
    chk("a we", 32'(bus_we), 32'h1);
    chk("a addr", bus_addr, 32'h2000);
    chk("a wdata", bus_wdata, 32'hDEADBEEF);
    chk("a sel", 32'(bus_sel), 32'hf);
    chk("a stall1", 32'(stall), 32'h1f);
    tick();
    bus_ack = 0;
    settle();
    chk("a mem_ack", 32'(mem_ack), 32'h1);
    chk("a if_ack", 32'(if_ack), 32'h0);
    chk("a mem_rdata", mem_rdata, 32'h0BADF00D);
    chk("a stall2", 32'(stall), 32'h03);
    tick();
    mem_req = 0; bus_ack = 1; bus_rdata = 32'h93;
    settle();
    chk("a if addr", bus_addr, 32'h140);
    chk("a if we", 32'(bus_we), 32'h0);
    chk("a if wdata", bus_wdata, 32'h0);
    tick();
    bus_ack = 0;
    settle();
    chk("a if_ack", 32'(if_ack), 32'h1);
    chk("a if_rdata", if_rdata, 32'h93);
    tick();
    if_req = 0;
    settle();
    tick();

    // Branch during a fetch drops that fetch.
    if_req = 1; if_addr = 32'h200;
    settle();
    tick();
    branch_flag = 1;
    settle();
    chk("b flush", 32'(flush), 32'h1);
    tick();
    branch_flag = 0; if_addr = 32'h300;
    bus_ack = 1; bus_rdata = 32'h77;
    settle();
    chk("b flush off", 32'(flush), 32'h0);
    chk("b addr held", bus_addr, 32'h200);
    tick();
    bus_ack = 0;
    settle();
    chk("b no ack", 32'(if_ack), 32'h0);
    chk("b rdata kept", if_rdata, 32'h93);
    tick();
    bus_ack = 1; bus_rdata = 32'h55;
    settle();
    chk("b refetch", bus_addr, 32'h300);
    tick();
    bus_ack = 0;
    settle();
    chk("b ack", 32'(if_ack), 32'h1);
    chk("b rdata", if_rdata, 32'h55);
    tick();
    if_req = 0;
    settle();
    tick();

    // Branch held off by EX stall; bus_ack in IDLE ignored.
    stallreq_ex = 1; branch_flag = 1; bus_ack = 1;
    settle();
    chk("x stall", 32'(stall), 32'h0f);
    chk("x flush", 32'(flush), 32'h0);
    tick();
    stallreq_ex = 0;
    settle();
    chk("x flush rel", 32'(flush), 32'h1);
    chk("x idle ack", 32'({if_ack, mem_ack}), 32'h0);
    tick();
    branch_flag = 0; bus_ack = 0;

    // Reset in the middle of a load.
    mem_req = 1; mem_we = 0; mem_addr = 32'h3000; mem_sel = 4'h3;
    settle();
    tick();
    settle();
    chk("r req", 32'(bus_req), 32'h1);
    rst = 0;
    #1;
    model_reset();
    chk("r req off", 32'(bus_req), 32'h0);
    chk("r addr", bus_addr, 32'h0);
    chk("r sel", 32'(bus_sel), 32'h0);
    chk("r stall", 32'(stall), 32'h1f);
    tick();
    chk("r no ack", 32'(mem_ack), 32'h0);
    chk("r req held", 32'(bus_req), 32'h0);
    mem_req = 0; rst = 1;
    settle();
    tick();

    // Load whose bus_ack never comes.
    mem_req = 1; mem_addr = 32'h4000;
    seen = 0; cnt = 0;
    for (int i = 0; i < 300; i++) begin
      settle();
      cnt = i;
      if (bus_timeout) begin
        seen = 1;
        break;
      end
      tick();
    end
`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
    chk("t seen", 32'(seen), 32'h1);
    chk("t cycles", 32'(cnt), 32'd256);
    chk("t mem_ack", 32'(mem_ack), 32'h1);
    chk("t rdata", mem_rdata, 32'h0);
    chk("t req", 32'(bus_req), 32'h0);
    tick();
    mem_req = 0;
`else
    chk("t none", 32'(seen), 32'h0);
    chk("t req", 32'(bus_req), 32'h1);
    chk("t addr", bus_addr, 32'h4000);
    bus_ack = 1; bus_rdata = 32'hA5;
    settle();
    tick();
    bus_ack = 0;
    settle();
    chk("t mem_ack", 32'(mem_ack), 32'h1);
    chk("t rdata", mem_rdata, 32'hA5);
    tick();
    mem_req = 0;
`endif

    // Randomized traffic.
    last_if = 0; last_mem = 0; last_fl = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!rst) rst = 1;
      else if ($urandom_range(499) == 0) rst = 0;
      if (last_mem) mem_req = 0;
      else if (!mem_req && $urandom_range(3) == 0) begin
        mem_req = 1;
        mem_we = 1'($urandom);
        mem_addr = $urandom;
        mem_wdata = $urandom;
        mem_sel = 4'($urandom);
      end
      if (last_if) if_req = 0;
      else if (if_req && last_fl) if_addr = $urandom;
      else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1;
        if_addr = $urandom;
      end
      stallreq_id = $urandom_range(7) == 0;
      stallreq_ex = $urandom_range(9) == 0;
      branch_flag = $urandom_range(7) == 0;
      bus_ack = $urandom_range(2) == 0;
      bus_rdata = $urandom;
      if (!rst) begin
        #1;
        model_reset();
      end
      settle();
      last_mem = m_mem_ack;
      last_if = m_if_ack;
      last_fl = exp_flush();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
